// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-side bundle of the parametrised synchronous FIFO.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
);
  logic [FIFO_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic                  err_clr;
  logic [FIFO_WIDTH-1:0] dout;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  ovf_sticky;
  logic                  udf_sticky;

  modport master (
    output din, wr_en, rd_en, err_clr,
    input  dout, wr_ack, overflow, underflow, full, empty,
           almost_full, almost_empty, count, ovf_sticky, udf_sticky
  );

  modport slave (
    input  din, wr_en, rd_en, err_clr,
    output dout, wr_ack, overflow, underflow, full, empty,
           almost_full, almost_empty, count, ovf_sticky, udf_sticky
  );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read port.
module fifo_mem #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_addr,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [PTR_W-1:0]      rd_addr,
  output logic [FIFO_WIDTH-1:0] rd_data
);
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Old contents are read when the same slot is written in this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy, status and error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  wr_acc, rd_acc;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  ovf_sticky_q, udf_sticky_q;
  logic [FIFO_WIDTH-1:0] dout_w;
  fifo_status_t          st;

  always_comb begin
    st.full         = (count_q == CNT_W'(FIFO_DEPTH));
    st.empty        = (count_q == '0);
    st.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    st.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  end

  // At full a write slips in only alongside a read that frees its slot.
  assign wr_acc = bus.wr_en && (!st.full || bus.rd_en);
  assign rd_acc = bus.rd_en && !st.empty;

  fifo_mem #(
    .FIFO_WIDTH(FIFO_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PTR_W     (PTR_W)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(bus.din),
    .rd_en  (rd_acc),
    .rd_addr(rd_ptr),
    .rd_data(dout_w)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), FIFO_DEPTH));
      if (rd_acc) rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), FIFO_DEPTH));
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      wr_ack_q    <= wr_acc;
      overflow_q  <= bus.wr_en && !wr_acc;
      underflow_q <= bus.rd_en && st.empty;
      // A fresh error outranks a coincident clear.
      if (bus.wr_en && !wr_acc) ovf_sticky_q <= 1'b1;
      else if (bus.err_clr)     ovf_sticky_q <= 1'b0;
      if (bus.rd_en && st.empty) udf_sticky_q <= 1'b1;
      else if (bus.err_clr)      udf_sticky_q <= 1'b0;
    end
  end

  assign bus.dout         = dout_w;
  assign bus.count        = count_q;
  assign bus.full         = st.full;
  assign bus.empty        = st.empty;
  assign bus.almost_full  = st.almost_full;
  assign bus.almost_empty = st.almost_empty;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.ovf_sticky   = ovf_sticky_q;
  assign bus.udf_sticky   = udf_sticky_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: an 8-deep and a 5-deep instance.
module tb_sync_fifo_param;
  logic clk;
  logic rst_n8, rst_n5;
  int   cyc;
  int   n_checks, n_errors;

  sync_fifo_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) if8 ();
  sync_fifo_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) if5 ();

  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u8 (
    .clk(clk), .rst_n(rst_n8), .bus(if8)
  );
  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) u5 (
    .clk(clk), .rst_n(rst_n5), .bus(if5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          k;
    int          due;
    logic [15:0] dout;
    int          cnt;
    logic        wa, ovf, udf, ovs, uds, full, empty, af, ae;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m0[$], m1[$];
  logic        ovs_m[2], uds_m[2];
  logic [15:0] dl_m[2];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: compares each expected record once its clock edge has passed.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.k == 0) begin
        chk("d8_dout", 32'(if8.dout), 32'(e.dout));
        chk("d8_count", 32'(if8.count), 32'(e.cnt));
        chk("d8_wr_ack", 32'(if8.wr_ack), 32'(e.wa));
        chk("d8_overflow", 32'(if8.overflow), 32'(e.ovf));
        chk("d8_underflow", 32'(if8.underflow), 32'(e.udf));
        chk("d8_ovf_sticky", 32'(if8.ovf_sticky), 32'(e.ovs));
        chk("d8_udf_sticky", 32'(if8.udf_sticky), 32'(e.uds));
        chk("d8_full", 32'(if8.full), 32'(e.full));
        chk("d8_empty", 32'(if8.empty), 32'(e.empty));
        chk("d8_almost_full", 32'(if8.almost_full), 32'(e.af));
        chk("d8_almost_empty", 32'(if8.almost_empty), 32'(e.ae));
      end else begin
        chk("d5_dout", 32'(if5.dout), 32'(e.dout));
        chk("d5_count", 32'(if5.count), 32'(e.cnt));
        chk("d5_wr_ack", 32'(if5.wr_ack), 32'(e.wa));
        chk("d5_overflow", 32'(if5.overflow), 32'(e.ovf));
        chk("d5_underflow", 32'(if5.underflow), 32'(e.udf));
        chk("d5_ovf_sticky", 32'(if5.ovf_sticky), 32'(e.ovs));
        chk("d5_udf_sticky", 32'(if5.udf_sticky), 32'(e.uds));
        chk("d5_full", 32'(if5.full), 32'(e.full));
        chk("d5_empty", 32'(if5.empty), 32'(e.empty));
        chk("d5_almost_full", 32'(if5.almost_full), 32'(e.af));
        chk("d5_almost_empty", 32'(if5.almost_empty), 32'(e.ae));
      end
    end
  end

  // One clock of stimulus on instance k; expected post-edge state is queued.
  task automatic step(input int k, input bit w, input bit r, input logic [15:0] di,
                      input bit clr, input bit rn);
    exp_t e;
    int   depth, cnt;
    bit   wa, ra, was_empty;
    depth = (k == 0) ? 8 : 5;
    if (k == 0) begin
      if8.wr_en = w; if8.rd_en = r; if8.din = di; if8.err_clr = clr; rst_n8 = rn;
    end else begin
      if5.wr_en = w; if5.rd_en = r; if5.din = di; if5.err_clr = clr; rst_n5 = rn;
    end
    e.k = k;
    e.due = cyc + 1;
    if (!rn) begin
      if (k == 0) m0.delete(); else m1.delete();
      ovs_m[k] = 1'b0; uds_m[k] = 1'b0; dl_m[k] = 16'h0;
      e.wa = 1'b0; e.ovf = 1'b0; e.udf = 1'b0;
    end else begin
      cnt = (k == 0) ? m0.size() : m1.size();
      was_empty = (cnt == 0);
      wa = w && ((cnt != depth) || r);
      ra = r && !was_empty;
      if (ra) dl_m[k] = (k == 0) ? m0.pop_front() : m1.pop_front();
      if (wa) begin
        if (k == 0) m0.push_back(di); else m1.push_back(di);
      end
      e.wa  = wa;
      e.ovf = w && !wa;
      e.udf = r && was_empty;
      if (e.ovf) ovs_m[k] = 1'b1; else if (clr) ovs_m[k] = 1'b0;
      if (e.udf) uds_m[k] = 1'b1; else if (clr) uds_m[k] = 1'b0;
    end
    e.cnt   = (k == 0) ? m0.size() : m1.size();
    e.dout  = dl_m[k];
    e.ovs   = ovs_m[k];
    e.uds   = uds_m[k];
    e.full  = (e.cnt == depth);
    e.empty = (e.cnt == 0);
    e.af    = (e.cnt >= depth - 1);
    e.ae    = (e.cnt <= 1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (k == 0) begin
      if8.wr_en = 0; if8.rd_en = 0; if8.err_clr = 0; rst_n8 = 1;
    end else begin
      if5.wr_en = 0; if5.rd_en = 0; if5.err_clr = 0; rst_n5 = 1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n8 = 0; rst_n5 = 0;
    if8.wr_en = 0; if8.rd_en = 0; if8.din = '0; if8.err_clr = 0;
    if5.wr_en = 0; if5.rd_en = 0; if5.din = '0; if5.err_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, 0, 16'h0, 0, 0);
    step(0, 0, 0, 16'h0, 0, 0);
    chk("rst_empty", 32'(if8.empty), 1);
    chk("rst_full", 32'(if8.full), 0);
    chk("rst_almost_empty", 32'(if8.almost_empty), 1);
    chk("rst_almost_full", 32'(if8.almost_full), 0);

    // Single write then read.
    step(0, 1, 0, 16'hA5A5, 0, 1);
    chk("wr1_ack", 32'(if8.wr_ack), 1);
    chk("wr1_count", 32'(if8.count), 1);
    step(0, 0, 1, 16'h0, 0, 1);
    chk("rd1_dout", 32'(if8.dout), 32'hA5A5);
    chk("rd1_empty", 32'(if8.empty), 1);

    // Fill, then overflow.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 16'(i), 0, 1);
      if (i == 6) chk("fill_af_at7", 32'(if8.almost_full), 1);
    end
    chk("fill_full", 32'(if8.full), 1);
    step(0, 1, 0, 16'h0009, 0, 1);
    chk("ovf_pulse", 32'(if8.overflow), 1);
    chk("ovf_no_ack", 32'(if8.wr_ack), 0);
    chk("ovf_count", 32'(if8.count), 8);
    chk("ovf_sticky", 32'(if8.ovf_sticky), 1);

    // Pass-through at full, then drain.
    step(0, 1, 1, 16'h00FF, 0, 1);
    chk("pt_ack", 32'(if8.wr_ack), 1);
    chk("pt_dout", 32'(if8.dout), 0);
    chk("pt_count", 32'(if8.count), 8);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 16'h0, 0, 1);
    chk("drain_last", 32'(if8.dout), 32'h00FF);

    // Empty with write+read; sticky clear and clear-vs-set.
    step(0, 1, 1, 16'h1234, 0, 1);
    chk("emp_udf", 32'(if8.underflow), 1);
    chk("emp_ack", 32'(if8.wr_ack), 1);
    chk("emp_count", 32'(if8.count), 1);
    step(0, 0, 0, 16'h0, 1, 1);
    chk("clr_udf_sticky", 32'(if8.udf_sticky), 0);
    step(0, 0, 1, 16'h0, 0, 1);
    chk("rd_1234", 32'(if8.dout), 32'h1234);
    step(0, 0, 1, 16'h0, 1, 1);
    chk("clr_vs_set", 32'(if8.udf_sticky), 1);

    // Reset mid-operation.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 16'h0100 + 16'(i), 0, 1);
    chk("pre_rst_count", 32'(if8.count), 6);
    step(0, 0, 0, 16'h0, 0, 0);
    chk("mid_rst_count", 32'(if8.count), 0);
    chk("mid_rst_empty", 32'(if8.empty), 1);
    step(0, 0, 1, 16'h0, 0, 1);
    chk("post_rst_udf", 32'(if8.underflow), 1);

    // Depth 5: steady occupancy of 3 across pointer wrap.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 16'h0500 + 16'(i), 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 1, 16'h0510 + 16'(i), 0, 1);
      chk("d5_steady_count", 32'(if5.count), 3);
    end
    chk("d5_dout_after_wrap", 32'(if5.dout), 32'h0518);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 16'h0, 0, 1);
    chk("d5_last", 32'(if5.dout), 32'h051B);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO. It is the next generation of the team's single-width, fixed-depth FIFO: width, depth and almost-full/almost-empty levels are configurable, and it adds an occupancy count, non-power-of-two depth, and read/write pass-through at full. It also adds sticky error flags with a clear input. It sits between producer and consumer stages in one clock domain and is the DUT for the UVM environment and its bound assertion module.

Parameters:
FIFO_WIDTH, 16, data width in bits (>=1)
FIFO_DEPTH, 8, number of entries (>=2, need not be a power of two)
AF_LEVEL, FIFO_DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..FIFO_DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..FIFO_DEPTH-1)
CNT_W, $clog2(FIFO_DEPTH+1), derived width of count; do not override

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
din  in  FIFO_WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read request
err_clr  in  1  clears sticky error flags
dout  out  FIFO_WIDTH  read data, registered
wr_ack  out  1  registered pulse: previous-cycle write accepted
overflow  out  1  registered pulse: previous-cycle write rejected
underflow  out  1  registered pulse: previous-cycle read rejected
full  out  1  count == FIFO_DEPTH (combinational from count)
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  CNT_W  current occupancy
ovf_sticky  out  1  latched overflow
udf_sticky  out  1  latched underflow

Behaviour:
- Clock is clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge. rst_n low at a clock edge sets all of the following, regardless of wr_en/rd_en in that cycle: wr_ptr=0, rd_ptr=0, count=0, dout=0, wr_ack=0, overflow=0, underflow=0, ovf_sticky=0, udf_sticky=0. Memory contents are not reset.
- Immediately after reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? n/a : 0).
- Write accept: wr_en && (!full || rd_en). When full, a write is accepted only together with a read, which frees the slot in the same cycle (pass-through).
- Read accept: rd_en && !empty. When empty with both requests asserted, only the write is accepted and the read underflows.
- Accepted write: mem[wr_ptr] <= din; wr_ptr advances.
- Accepted read: dout <= mem[rd_ptr] at the same edge, giving 1-cycle latency; rd_ptr advances. dout holds its value when no read is accepted.
- Pointer wrap: a pointer at FIFO_DEPTH-1 goes to 0. Explicit compare, no power-of-two masking.
- count update per edge:
  - +1 on write-only accept
  - -1 on read-only accept
  - unchanged when both are accepted or neither is
- Next-edge flags:
  - wr_ack <= write accepted
  - overflow <= wr_en && !write accepted
  - underflow <= rd_en && empty
  - Each flag is a 1-cycle pulse per offending cycle.
- Sticky flags:
  - ovf_sticky sets on any cycle that sets overflow; udf_sticky likewise for underflow.
  - err_clr clears both.
  - If err_clr and a new error occur in the same cycle, the set wins.
- full, empty, almost_full and almost_empty are combinational from the count register only. They carry no input-to-output paths.
- Reset mid-operation discards all stored data; the first read after reset underflows.

Decomposition:
- Package fifo_pkg:
  - fifo_status_t packed struct {full, empty, almost_full, almost_empty}
  - function ptr_inc(ptr, depth) for wrap increment
  - localparam defaults for FIFO_WIDTH and FIFO_DEPTH
- Sub-module fifo_mem: FIFO_DEPTH x FIFO_WIDTH simple dual-port RAM with synchronous write and registered read; the read register feeds dout.
- The top level holds pointers, count, flags and sticky logic.

Test Plan:
- Reset then single write din=16'hA5A5 -> wr_ack=1 next cycle, count=1, empty=0. Read -> dout=16'hA5A5 one cycle later, count=0, empty=1.
- Fill DEPTH=8 with 0..7 -> full=1 after 8th write; almost_full=1 at count=7. 9th write -> overflow=1 one cycle later, wr_ack=0, count stays 8, ovf_sticky=1.
- Full with wr_en=rd_en=1, din=16'h00FF -> wr_ack=1, dout=0 (oldest), count stays 8. After draining, last dout=16'h00FF.
- Empty with wr_en=rd_en=1, din=16'h1234 -> underflow=1, wr_ack=1, count=1, udf_sticky=1. err_clr pulse -> udf_sticky=0. err_clr coincident with another underflow -> udf_sticky stays 1.
- DEPTH=5, 12 writes interleaved with 12 reads, occupancy kept at 3 -> data order preserved across pointer wrap 4->0, count never exceeds 5.
- rst_n=0 for one cycle at count=6 -> next cycle count=0, empty=1, flags 0. A read then gives underflow=1.
